stump_control_unit: RTL and testbench

//  Control unit of the 16-bit Stump processor. A 3-state sequencer (fetch/execute/memory)

---
 rtl/stump_control_unit_pkg.sv | 66 ++++++
 rtl/stump_control_unit_if.sv | 31 +++
 rtl/stump_control_unit_cond.sv | 37 +++
 rtl/stump_control_unit.sv | 138 +++++++++++++
 tb/tb_stump_control_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stump_control_unit_pkg.sv
// Shared constants for the Stump control unit: sequencer state encoding,
// opcodes, ALU function codes, shifter codes and branch condition codes.
package stump_pkg;

   // sequencer state encoding; 2'b11 is unused and recovers to FETCH
   localparam logic [1:0] ST_FETCH   = 2'b00;
   localparam logic [1:0] ST_EXECUTE = 2'b01;
   localparam logic [1:0] ST_MEMORY  = 2'b10;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADC  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_SBC  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_LDST = 3'b110;
   localparam logic [2:0] OP_BCC  = 3'b111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_ADC = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_SBC = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_ASR  = 2'b01;
   localparam logic [1:0] SH_ROR  = 2'b10;
   localparam logic [1:0] SH_RRC  = 2'b11;

   localparam logic [3:0] COND_AL = 4'h0;
   localparam logic [3:0] COND_NV = 4'h1;
   localparam logic [3:0] COND_HI = 4'h2;
   localparam logic [3:0] COND_LS = 4'h3;
   localparam logic [3:0] COND_CC = 4'h4;
   localparam logic [3:0] COND_CS = 4'h5;
   localparam logic [3:0] COND_NE = 4'h6;
   localparam logic [3:0] COND_EQ = 4'h7;
   localparam logic [3:0] COND_VC = 4'h8;
   localparam logic [3:0] COND_VS = 4'h9;
   localparam logic [3:0] COND_PL = 4'hA;
   localparam logic [3:0] COND_MI = 4'hB;
   localparam logic [3:0] COND_GE = 4'hC;
   localparam logic [3:0] COND_LT = 4'hD;
   localparam logic [3:0] COND_GT = 4'hE;
   localparam logic [3:0] COND_LE = 4'hF;

   localparam logic [2:0] PC_REG = 3'd7;

   // field view of an instruction word; layout matches ir[15:0] bit for bit
   typedef struct packed {
      logic [2:0] op;
      logic       typ;
      logic       s;
      logic [2:0] rd;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [1:0] sh;
   } ir_fields_t;

   // branch condition lives where S and rd sit for data-processing ops
   function automatic logic [3:0] branch_cond(input ir_fields_t f);
      return {f.s, f.rd};
   endfunction

endpackage

// File: rtl/stump_control_unit_if.sv
// Bundle between the control unit and the Stump datapath / IR / flag register.
interface stump_control_unit_if;
   logic [3:0]  cc;
   logic [15:0] ir;
   logic        fetch;
   logic        execute;
   logic        memory;
   logic        ext_op;
   logic        reg_write;
   logic [2:0]  dest;
   logic [2:0]  srcA;
   logic [2:0]  srcB;
   logic [1:0]  shift_op;
   logic        opB_mux_sel;
   logic [2:0]  alu_func;
   logic        cc_en;
   logic        mem_ren;
   logic        mem_wen;

   modport master (
      input  cc, ir,
      output fetch, execute, memory, ext_op, reg_write, dest, srcA, srcB,
             shift_op, opB_mux_sel, alu_func, cc_en, mem_ren, mem_wen
   );

   modport slave (
      output cc, ir,
      input  fetch, execute, memory, ext_op, reg_write, dest, srcA, srcB,
             shift_op, opB_mux_sel, alu_func, cc_en, mem_ren, mem_wen
   );
endinterface

// File: rtl/stump_control_unit_cond.sv
// Branch condition evaluator: flags {N,Z,V,C} against a 4-bit condition code.
module stump_cond_eval
   import stump_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] cc_i,
   output logic       taken_o
);

   logic n, z, v, c;
   assign {n, z, v, c} = cc_i;

   // truth table of the sixteen branch conditions
   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         COND_AL: taken_o = 1'b1;
         COND_NV: taken_o = 1'b0;
         COND_HI: taken_o = ~c & ~z;
         COND_LS: taken_o = c | z;
         COND_CC: taken_o = ~c;
         COND_CS: taken_o = c;
         COND_NE: taken_o = ~z;
         COND_EQ: taken_o = z;
         COND_VC: taken_o = ~v;
         COND_VS: taken_o = v;
         COND_PL: taken_o = ~n;
         COND_MI: taken_o = n;
         COND_GE: taken_o = (n == v);
         COND_LT: taken_o = (n != v);
         COND_GT: taken_o = ~z & (n == v);
         COND_LE: taken_o = z | (n != v);
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/stump_control_unit.sv
// Stump control unit: fetch/execute/memory sequencer plus combinational decode.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_FETCH   | read instruction at PC, PC <= PC + 1
//  ST_EXECUTE | ALU op, LD/ST address calculation, or conditional branch
//  ST_MEMORY  | LD writes rd from memory, ST writes rd out to memory
module stump_control_unit
   import stump_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   stump_control_unit_if.master bus
);

   logic [1:0] state_q, state_d;
   ir_fields_t f;
   logic       taken;

   logic       fetch_c, execute_c, memory_c, ext_op_c, reg_write_c;
   logic [2:0] dest_c, src_a_c, src_b_c, alu_func_c;
   logic [1:0] shift_op_c;
   logic       opb_sel_c, cc_en_c, mem_ren_c, mem_wen_c;

   assign f = ir_fields_t'(bus.ir);

   stump_cond_eval u_cond (
      .cond_i  (branch_cond(f)),
      .cc_i    (bus.cc),
      .taken_o (taken)
   );

   // next-state: only LD/ST visits MEMORY; the spare encoding recovers to FETCH
   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH:   state_d = ST_EXECUTE;
         ST_EXECUTE: state_d = (f.op == OP_LDST) ? ST_MEMORY : ST_FETCH;
         ST_MEMORY:  state_d = ST_FETCH;
         default:    state_d = ST_FETCH;
      endcase
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_FETCH;
      else      state_q <= state_d;
   end

   // datapath control decode from state, instruction and branch outcome
   always_comb begin
      fetch_c     = 1'b0;
      execute_c   = 1'b0;
      memory_c    = 1'b0;
      ext_op_c    = 1'b0;
      reg_write_c = 1'b0;
      dest_c      = 3'd0;
      src_a_c     = 3'd0;
      src_b_c     = 3'd0;
      shift_op_c  = SH_NONE;
      opb_sel_c   = 1'b0;
      alu_func_c  = ALU_ADD;
      cc_en_c     = 1'b0;
      mem_ren_c   = 1'b0;
      mem_wen_c   = 1'b0;
      case (state_q)
         ST_EXECUTE: begin
            execute_c = 1'b1;
            case (f.op)
               OP_LDST: begin
                  alu_func_c = ALU_ADD;
                  src_a_c    = f.ra;
                  src_b_c    = f.rb;
                  opb_sel_c  = f.typ;
                  shift_op_c = f.typ ? SH_NONE : f.sh;
               end
               OP_BCC: begin
                  src_a_c     = PC_REG;
                  dest_c      = PC_REG;
                  alu_func_c  = ALU_ADD;
                  opb_sel_c   = 1'b1;
                  ext_op_c    = 1'b1;
                  reg_write_c = taken;
               end
               default: begin
                  // data-processing opcodes map straight onto ALU function codes
                  alu_func_c  = f.op;
                  dest_c      = f.rd;
                  src_a_c     = f.ra;
                  src_b_c     = f.rb;
                  opb_sel_c   = f.typ;
                  shift_op_c  = f.typ ? SH_NONE : f.sh;
                  cc_en_c     = f.s;
                  reg_write_c = 1'b1;
               end
            endcase
         end
         ST_MEMORY: begin
            memory_c = 1'b1;
            if (f.s) begin
               mem_wen_c = 1'b1;
               src_b_c   = f.rd;
            end else begin
               mem_ren_c   = 1'b1;
               dest_c      = f.rd;
               reg_write_c = 1'b1;
            end
         end
         default: begin
            // FETCH, and the spare encoding behaves as FETCH so one strobe is always high
            fetch_c     = 1'b1;
            mem_ren_c   = 1'b1;
            src_a_c     = PC_REG;
            dest_c      = PC_REG;
            alu_func_c  = ALU_ADD;
            opb_sel_c   = 1'b1;
            reg_write_c = 1'b1;
         end
      endcase
   end

   assign bus.fetch       = fetch_c;
   assign bus.execute     = execute_c;
   assign bus.memory      = memory_c;
   assign bus.ext_op      = ext_op_c;
   assign bus.dest        = dest_c;
   assign bus.srcA        = src_a_c;
   assign bus.srcB        = src_b_c;
   assign bus.shift_op    = shift_op_c;
   assign bus.opB_mux_sel = opb_sel_c;
   assign bus.alu_func    = alu_func_c;
   assign bus.mem_ren     = mem_ren_c;
   // state-changing strobes are held off for the whole time reset is asserted
   assign bus.reg_write   = reg_write_c & rst;
   assign bus.cc_en       = cc_en_c & rst;
   assign bus.mem_wen     = mem_wen_c & rst;

endmodule

// File: tb/tb_stump_control_unit.sv
// Scoreboard bench for the Stump control unit.
module tb_stump_control_unit;
   import stump_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stump_control_unit_if bus ();

   stump_control_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic       fetch;
      logic       execute;
      logic       memory;
      logic       ext_op;
      logic       reg_write;
      logic [2:0] dest;
      logic [2:0] srca;
      logic [2:0] srcb;
      logic [1:0] shift_op;
      logic       opb;
      logic [2:0] alu;
      logic       cc_en;
      logic       mem_ren;
      logic       mem_wen;
   } out_t;

   out_t  exp_q[$];
   out_t  msk_q[$];
   string nm_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic out_t m_all();
      out_t m;
      m = '1;
      return m;
   endfunction

   function automatic out_t m_strobes();
      out_t m;
      m = '0;
      m.fetch = 1'b1; m.execute = 1'b1; m.memory = 1'b1;
      return m;
   endfunction

   function automatic out_t o_zero();
      out_t o;
      o = '0;
      return o;
   endfunction

   function automatic out_t o_fetch();
      out_t o;
      o = '0;
      o.fetch = 1'b1; o.mem_ren = 1'b1; o.srca = 3'd7; o.dest = 3'd7;
      o.opb = 1'b1; o.reg_write = 1'b1;
      return o;
   endfunction

   // independent statement of the branch truth table
   function automatic logic cond_ref(input int cond, input int flags);
      logic n, z, v, c;
      n = flags[3]; z = flags[2]; v = flags[1]; c = flags[0];
      case (cond)
         0:  return 1'b1;
         1:  return 1'b0;
         2:  return !c && !z;
         3:  return c || z;
         4:  return !c;
         5:  return c;
         6:  return !z;
         7:  return z;
         8:  return !v;
         9:  return v;
         10: return !n;
         11: return n;
         12: return n == v;
         13: return n != v;
         14: return !z && (n == v);
         default: return z || (n != v);
      endcase
   endfunction

   // queue the expectation for the current cycle, then advance one clock
   task automatic expect_cycle(input string nm, input out_t e, input out_t m);
      exp_q.push_back(e);
      msk_q.push_back(m);
      nm_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // monitor: every cycle with a pending expectation is compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         out_t  act, e, m;
         string nm;
         act.fetch     = bus.fetch;
         act.execute   = bus.execute;
         act.memory    = bus.memory;
         act.ext_op    = bus.ext_op;
         act.reg_write = bus.reg_write;
         act.dest      = bus.dest;
         act.srca      = bus.srcA;
         act.srcb      = bus.srcB;
         act.shift_op  = bus.shift_op;
         act.opb       = bus.opB_mux_sel;
         act.alu       = bus.alu_func;
         act.cc_en     = bus.cc_en;
         act.mem_ren   = bus.mem_ren;
         act.mem_wen   = bus.mem_wen;
         e  = exp_q.pop_front();
         m  = msk_q.pop_front();
         nm = nm_q.pop_front();
         n_checks++;
         if (((act ^ e) & m) != '0) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (mask %h) ir=%h cc=%h",
                     nm, act & m, e & m, m, bus.ir, bus.cc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      out_t e, m;
      logic [2:0] op3;

      bus.ir = 16'h0000;
      bus.cc = 4'h0;
      rst    = 1'b0;

      // reset held over two edges; gated strobes stay low
      @(posedge clk); #1;
      e = o_fetch(); e.reg_write = 1'b0;
      expect_cycle("reset_fetch_gated", e, m_all());
      rst = 1'b1;
      expect_cycle("nop_fetch", o_fetch(), m_all());
      e = o_zero(); e.execute = 1'b1; e.reg_write = 1'b1;
      expect_cycle("nop_execute", e, m_all());

      // ADD S r3,r2,r1 ASR
      bus.ir = 16'h0B45;
      expect_cycle("add_fetch", o_fetch(), m_all());
      e = o_zero(); e.execute = 1'b1; e.alu = 3'b000; e.dest = 3'd3; e.srca = 3'd2;
      e.srcb = 3'd1; e.shift_op = 2'b01; e.opb = 1'b0; e.cc_en = 1'b1; e.reg_write = 1'b1;
      expect_cycle("add_reg_execute", e, m_all());

      // SUB immediate, no flag update, shift suppressed
      bus.ir = 16'h5205;
      expect_cycle("sub_fetch", o_fetch(), m_all());
      e = o_zero(); e.execute = 1'b1; e.alu = 3'b010; e.dest = 3'd2; e.srca = 3'd0;
      e.srcb = 3'd1; e.opb = 1'b1; e.reg_write = 1'b1;
      expect_cycle("sub_imm_execute", e, m_all());

      // LD r1,[r2,r0]
      bus.ir = 16'hC140;
      expect_cycle("ld_fetch", o_fetch(), m_all());
      e = o_zero(); e.execute = 1'b1; e.srca = 3'd2;
      expect_cycle("ld_execute", e, m_all());
      e = o_zero(); e.memory = 1'b1; e.mem_ren = 1'b1; e.dest = 3'd1; e.reg_write = 1'b1;
      expect_cycle("ld_memory", e, m_all());

      // ST r1,[r2,r0]
      bus.ir = 16'hC940;
      expect_cycle("ld_to_fetch", o_fetch(), m_all());
      e = o_zero(); e.execute = 1'b1; e.srca = 3'd2;
      expect_cycle("st_execute", e, m_all());
      e = o_zero(); e.memory = 1'b1; e.mem_wen = 1'b1; e.srcb = 3'd1;
      expect_cycle("st_memory", e, m_all());

      // BEQ taken then not taken
      bus.ir = 16'hE705;
      bus.cc = 4'b0100;
      expect_cycle("st_to_fetch", o_fetch(), m_all());
      e = o_zero(); e.execute = 1'b1; e.srca = 3'd7; e.dest = 3'd7; e.opb = 1'b1;
      e.ext_op = 1'b1; e.reg_write = 1'b1;
      expect_cycle("beq_taken", e, m_all());
      bus.cc = 4'b0000;
      expect_cycle("beq_fetch", o_fetch(), m_all());
      e.reg_write = 1'b0;
      expect_cycle("beq_not_taken", e, m_all());

      // reset during LD execute aborts it: no MEMORY cycle follows
      bus.ir = 16'hC140;
      expect_cycle("abort_ld_fetch", o_fetch(), m_all());
      rst = 1'b0;
      e = o_zero(); e.execute = 1'b1; e.srca = 3'd2;
      expect_cycle("abort_ld_execute", e, m_all());
      rst = 1'b1;
      expect_cycle("abort_ld_refetch", o_fetch(), m_all());

      // reset during ST memory gates the write strobe
      bus.ir = 16'hC940;
      e = o_zero(); e.execute = 1'b1; e.srca = 3'd2;
      expect_cycle("abort_st_execute", e, m_all());
      rst = 1'b0;
      e = o_zero(); e.memory = 1'b1; e.srcb = 3'd1;
      expect_cycle("abort_st_memory_gated", e, m_all());
      rst = 1'b1;
      expect_cycle("abort_st_refetch", o_fetch(), m_all());

      // all 16 conditions against all 16 flag values
      m = o_zero(); m.execute = 1'b1; m.reg_write = 1'b1;
      for (int c = 0; c < 16; c++) begin
         for (int k = 0; k < 16; k++) begin
            bus.ir = {3'b111, 1'b1, c[3:0], 8'h05};
            bus.cc = k[3:0];
            e = o_zero(); e.execute = 1'b1; e.reg_write = cond_ref(c, k);
            expect_cycle($sformatf("cond_%0d_cc_%0d", c, k), e, m);
            expect_cycle("cond_sweep_fetch", o_fetch(), m_strobes());
         end
      end

      // opcode sweep: only op 110 visits MEMORY
      bus.cc = 4'h0;
      for (int h = 0; h < 16; h++) begin
         bus.ir = {h[3:0], 12'h000};
         op3    = h[3:1];
         e = o_zero(); e.execute = 1'b1;
         expect_cycle($sformatf("opsweep_%0h_execute", h), e, m_strobes());
         e = o_zero();
         if (op3 == 3'b110) begin
            e.memory = 1'b1;
            expect_cycle($sformatf("opsweep_%0h_memory", h), e, m_strobes());
         end
         expect_cycle($sformatf("opsweep_%0h_fetch", h), o_fetch(), m_strobes());
      end

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
